// File: rtl/muldiv_ctrl_if.sv
// Handshake/data bundle between the E stage and the multiply/divide controller.
// Signals:
//   start, op[1:0], a, b  - operation request and operands from the pipeline
//   flush                 - cancel the current operation
//   ack                   - E stage advances and consumes the result
//   ok                    - 0 stalls E (combinational from the controller)
//   valid, hi, lo         - finished result registers
// Modports: master (pipeline side), slave (controller side).
interface muldiv_ctrl_if #(
  parameter int unsigned DATA_W = 32
);
  logic              start;
  logic [1:0]        op;
  logic [DATA_W-1:0] a;
  logic [DATA_W-1:0] b;
  logic              flush;
  logic              ack;
  logic              ok;
  logic              valid;
  logic [DATA_W-1:0] hi;
  logic [DATA_W-1:0] lo;

  modport master (
    output start, op, a, b, flush, ack,
    input  ok, valid, hi, lo
  );

  modport slave (
    input  start, op, a, b, flush, ack,
    output ok, valid, hi, lo
  );
endinterface

// File: rtl/muldiv_ctrl.sv
// Iterative multiply/divide unit for the E stage (MULT, MULTU, DIV, DIVU).
// Ports:
//   clk     - rising-edge clock
//   reset   - asynchronous active-high reset
//   bus_io  - muldiv_ctrl_if.slave: start/op/a/b/flush/ack in, ok/valid/hi/lo out
// Multiply is shift-add and divide is restoring, one bit per cycle on operand
// magnitudes, with sign fix-up on the final step. A divide by zero finishes in
// one cycle with lo=all ones and hi=a.
// Build option: define MULDIV_FAST_MUL_EN for a single-cycle registered multiply.
module muldiv_ctrl #(
  parameter int unsigned DATA_W = 32
) (
  input logic           clk,
  input logic           reset,
  muldiv_ctrl_if.slave  bus_io
);
  localparam int unsigned W = DATA_W;

  typedef enum logic [1:0] {StIdle, StMul, StDiv, StDone} state_e;

  state_e           state_q, state_d;
  logic [4:0]       cnt_q, cnt_d;
  // Working register: multiply {acc, multiplier}, divide {remainder, dividend/quotient}.
  logic [2*W-1:0]   prod_q, prod_d;
  logic [W-1:0]     dvsr_q, dvsr_d;
  logic             neg_q, neg_d;          // negate product / quotient
  logic             neg_rem_q, neg_rem_d;  // negate remainder (also a's sign extension)
  logic             zero_q, zero_d;        // divide by zero pending
  logic [W-1:0]     hi_q, hi_d, lo_q, lo_d;
  logic             valid_q, valid_d;
  logic             ok_o;

  logic             sgn;
  logic [W-1:0]     mag_a, mag_b;
  logic             last;
  logic [W+1:0]     div_trial;
  logic [2*W-1:0]   div_next;
  logic [2*W-1:0]   mul_res;

  assign sgn   = ~bus_io.op[0];
  assign mag_a = (sgn && bus_io.a[W-1]) ? -bus_io.a : bus_io.a;
  assign mag_b = (sgn && bus_io.b[W-1]) ? -bus_io.b : bus_io.b;
  assign last  = (cnt_q == 5'd31);

  // Restoring divide step: shift in the next dividend bit and try to subtract.
  assign div_trial = {1'b0, prod_q[2*W-1:W], prod_q[W-1]} - {2'b00, dvsr_q};
  assign div_next  = div_trial[W+1] ? {prod_q[2*W-2:0], 1'b0}
                                    : {div_trial[W-1:0], prod_q[W-2:0], 1'b1};

`ifdef MULDIV_FAST_MUL_EN
  logic [2*W-1:0] mul_a, mul_b;
  // Operands were captured raw; a's sign extension is neg_rem_q and b's is
  // neg_q ^ neg_rem_q (both zero for unsigned ops).
  assign mul_a   = {{W{neg_rem_q}}, prod_q[W-1:0]};
  assign mul_b   = {{W{neg_q ^ neg_rem_q}}, dvsr_q};
  assign mul_res = mul_a * mul_b;
`else
  logic [W:0]     mul_add;
  logic [2*W-1:0] mul_next;
  assign mul_add  = {1'b0, prod_q[2*W-1:W]} + (prod_q[0] ? {1'b0, dvsr_q} : '0);
  assign mul_next = {mul_add, prod_q[W-1:1]};
  assign mul_res  = neg_q ? -mul_next : mul_next;
`endif

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      prod_q    <= '0;
      dvsr_q    <= '0;
      neg_q     <= 1'b0;
      neg_rem_q <= 1'b0;
      zero_q    <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      prod_q    <= prod_d;
      dvsr_q    <= dvsr_d;
      neg_q     <= neg_d;
      neg_rem_q <= neg_rem_d;
      zero_q    <= zero_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      valid_q   <= valid_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (bus_io.start) state_d = bus_io.op[1] ? StDiv : StMul;
`ifdef MULDIV_FAST_MUL_EN
      StMul:  state_d = StDone;
`else
      StMul:  if (last) state_d = StDone;
`endif
      StDiv:  if (zero_q || last) state_d = StDone;
      StDone: if (bus_io.ack) state_d = StIdle;
      default: state_d = StIdle;
    endcase
    if (bus_io.flush) state_d = StIdle;
  end

  // Datapath next-state
  always_comb begin
    cnt_d     = cnt_q;
    prod_d    = prod_q;
    dvsr_d    = dvsr_q;
    neg_d     = neg_q;
    neg_rem_d = neg_rem_q;
    zero_d    = zero_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    valid_d   = valid_q;
    unique case (state_q)
      StIdle: begin
        if (bus_io.start) begin
          cnt_d     = '0;
          neg_d     = sgn & (bus_io.a[W-1] ^ bus_io.b[W-1]);
          neg_rem_d = sgn & bus_io.a[W-1];
          zero_d    = 1'b0;
          prod_d    = {{W{1'b0}}, mag_a};
          dvsr_d    = mag_b;
          if (bus_io.op[1] && (bus_io.b == '0)) begin
            zero_d = 1'b1;
            prod_d = {bus_io.a, {W{1'b1}}};
          end
`ifdef MULDIV_FAST_MUL_EN
          if (!bus_io.op[1]) begin
            prod_d = {{W{1'b0}}, bus_io.a};
            dvsr_d = bus_io.b;
          end
`endif
        end
      end
      StMul: begin
`ifdef MULDIV_FAST_MUL_EN
        hi_d    = mul_res[2*W-1:W];
        lo_d    = mul_res[W-1:0];
        valid_d = 1'b1;
`else
        prod_d = mul_next;
        cnt_d  = cnt_q + 5'd1;
        if (last) begin
          hi_d    = mul_res[2*W-1:W];
          lo_d    = mul_res[W-1:0];
          valid_d = 1'b1;
        end
`endif
      end
      StDiv: begin
        if (zero_q) begin
          hi_d    = prod_q[2*W-1:W];
          lo_d    = prod_q[W-1:0];
          valid_d = 1'b1;
        end else begin
          prod_d = div_next;
          cnt_d  = cnt_q + 5'd1;
          if (last) begin
            lo_d    = neg_q ? -div_next[W-1:0] : div_next[W-1:0];
            hi_d    = neg_rem_q ? -div_next[2*W-1:W] : div_next[2*W-1:W];
            valid_d = 1'b1;
          end
        end
      end
      StDone: if (bus_io.ack) valid_d = 1'b0;
      default: ;
    endcase
    // A cancelled op leaves the previous hi/lo untouched.
    if (bus_io.flush) begin
      hi_d    = hi_q;
      lo_d    = lo_q;
      valid_d = 1'b0;
    end
  end

  // Outputs
  always_comb begin
    ok_o = ((state_q == StIdle) && !bus_io.start) || (state_q == StDone);
  end

  assign bus_io.ok    = ok_o;
  assign bus_io.valid = valid_q;
  assign bus_io.hi    = hi_q;
  assign bus_io.lo    = lo_q;
endmodule

// File: tb/tb_muldiv_ctrl.sv
module tb_muldiv_ctrl;
`ifdef MULDIV_FAST_MUL_EN
  localparam int MulLat = 2;
`else
  localparam int MulLat = 33;
`endif

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  muldiv_ctrl_if #(.DATA_W(32)) bus ();

  muldiv_ctrl #(.DATA_W(32)) dut (
    .clk    (clk),
    .reset  (reset),
    .bus_io (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Start at cycle T, expect valid first at T+lat, then consume with ack.
  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] av,
                        input logic [31:0] bv, input int lat, input logic ack_busy,
                        input logic [31:0] eh, input logic [31:0] el);
    bus.start = 1'b1;
    bus.op    = o;
    bus.a     = av;
    bus.b     = bv;
    #1;
    chk({tag, "_ok_drop"}, {63'd0, bus.ok}, 64'd0);
    tick();
    bus.start = 1'b0;
    bus.a     = 32'h0;
    bus.b     = 32'h0;
    bus.ack   = ack_busy;
    repeat (lat - 2) tick();
    chk({tag, "_valid_early"}, {63'd0, bus.valid}, 64'd0);
    tick();
    chk({tag, "_valid"}, {63'd0, bus.valid}, 64'd1);
    chk({tag, "_hi"}, {32'd0, bus.hi}, {32'd0, eh});
    chk({tag, "_lo"}, {32'd0, bus.lo}, {32'd0, el});
    bus.ack = 1'b1;
    tick();
    bus.ack = 1'b0;
    chk({tag, "_valid_after_ack"}, {63'd0, bus.valid}, 64'd0);
  endtask

  initial begin
    logic seen_valid;
    logic stable;
    checks     = 0;
    failures   = 0;
    bus.start  = 1'b0;
    bus.op     = 2'b00;
    bus.a      = 32'h0;
    bus.b      = 32'h0;
    bus.flush  = 1'b0;
    bus.ack    = 1'b0;
    reset      = 1'b1;
    #2;
    chk("reset_valid", {63'd0, bus.valid}, 64'd0);
    chk("reset_hi", {32'd0, bus.hi}, 64'd0);
    chk("reset_lo", {32'd0, bus.lo}, 64'd0);
    chk("reset_ok", {63'd0, bus.ok}, 64'd1);
    tick();
    reset = 1'b0;
    tick();

    run_op("mult_neg", 2'b00, 32'hFFFF_FFFD, 32'd7, MulLat, 1'b0,
           32'hFFFF_FFFF, 32'hFFFF_FFEB);
    run_op("divu_100_7", 2'b11, 32'd100, 32'd7, 33, 1'b0, 32'd2, 32'd14);
    // ack held high while busy must be ignored
    run_op("div_neg", 2'b10, 32'hFFFF_FFF9, 32'd2, 33, 1'b1,
           32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 33, 1'b0,
           32'h0, 32'h8000_0000);
    run_op("div_by0", 2'b10, 32'd5, 32'd0, 2, 1'b0, 32'd5, 32'hFFFF_FFFF);

    // Flush at T+10 of a DIVU
    bus.start = 1'b1;
    bus.op    = 2'b11;
    bus.a     = 32'd100;
    bus.b     = 32'd7;
    tick();
    bus.start = 1'b0;
    repeat (9) tick();
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    chk("flush_ok_idle", {63'd0, bus.ok}, 64'd1);
    chk("flush_valid", {63'd0, bus.valid}, 64'd0);
    chk("flush_hi_kept", {32'd0, bus.hi}, 64'd5);
    chk("flush_lo_kept", {32'd0, bus.lo}, 64'h0000_0000_FFFF_FFFF);
    seen_valid = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (bus.valid) seen_valid = 1'b1;
    end
    chk("flush_no_valid", {63'd0, seen_valid}, 64'd0);

    // DONE hold with ack=0 for 5 cycles; start in DONE is ignored
    bus.start = 1'b1;
    bus.op    = 2'b11;
    bus.a     = 32'd100;
    bus.b     = 32'd7;
    tick();
    bus.start = 1'b0;
    repeat (32) tick();
    stable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus.start = 1'b1;
      bus.op    = 2'b01;
      bus.a     = 32'h1234;
      bus.b     = 32'h5678;
      #1;
      if (!(bus.valid === 1'b1 && bus.hi === 32'd2 && bus.lo === 32'd14 && bus.ok === 1'b1))
        stable = 1'b0;
      tick();
    end
    chk("done_hold_stable", {63'd0, stable}, 64'd1);
    chk("done_hold_lo", {32'd0, bus.lo}, 64'd14);
    bus.start = 1'b0;
    bus.ack   = 1'b1;
    tick();
    bus.ack = 1'b0;
    chk("done_ack_valid", {63'd0, bus.valid}, 64'd0);
    chk("done_ack_ok", {63'd0, bus.ok}, 64'd1);

    // Asynchronous reset at T+20 of a MULTU
    bus.start = 1'b1;
    bus.op    = 2'b01;
    bus.a     = 32'hFFFF_FFFF;
    bus.b     = 32'hFFFF_FFFF;
    tick();
    bus.start = 1'b0;
    repeat (19) tick();
    reset = 1'b1;
    #1;
    chk("rst_mid_valid", {63'd0, bus.valid}, 64'd0);
    chk("rst_mid_hi", {32'd0, bus.hi}, 64'd0);
    chk("rst_mid_lo", {32'd0, bus.lo}, 64'd0);
    chk("rst_mid_ok", {63'd0, bus.ok}, 64'd1);
    reset = 1'b0;
    tick();
    run_op("multu_after_rst", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MulLat, 1'b0,
           32'hFFFF_FFFE, 32'h0000_0001);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/muldiv_ctrl.md
MULDIV_CTRL -- requirements
Module: muldiv_ctrl

Interface
REQ-001 SHALL have one clock and an asynchronous, active-high reset; the clock port is clk and the reset port is reset.
REQ-002 SHALL have parameter: DATA_W, 32, operand and result width (only 32 supported).
REQ-003 SHALL have port: clk  in  1  rising-edge clock.
REQ-004 SHALL have port: reset  in  1  asynchronous active-high reset.
REQ-005 SHALL have port: start  in  1  E-stage holds a mult/div op; sampled in IDLE only.
REQ-006 SHALL have port: op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU; captured with start.
REQ-007 SHALL have port: a  in  32  rs operand; captured with start.
REQ-008 SHALL have port: b  in  32  rt operand; captured with start.
REQ-009 SHALL have port: flush  in  1  cancel the current op (exception/eret).
REQ-010 SHALL have port: ack  in  1  E stage advances; the result is consumed.
REQ-011 SHALL have port: ok  out  1  combinational; 0 stalls E (feeds the hazard unit mult_ok).
REQ-012 SHALL have port: valid  out  1  hi/lo hold a finished result.
REQ-013 SHALL have port: hi  out  32  product high word or remainder.
REQ-014 SHALL have port: lo  out  32  product low word or quotient.

Function
REQ-015 SHALL implement the states IDLE, MUL, DIV and DONE, with a 5-bit iteration counter.
REQ-016 SHALL, in IDLE with start=1 and flush=0, capture op/a/b and go to MUL (op[1]=0) or DIV (op[1]=1), with the counter cleared.
REQ-017 SHALL drive ok = (IDLE & ~start) | DONE, so that ok drops in the same cycle start is first seen.
REQ-018 SHALL, in MUL, perform a shift-add on operand magnitudes one bit per cycle for 32 cycles, then go to DONE; signed ops negate the 64-bit result when a[31]^b[31].
REQ-019 SHALL, in DIV, perform a restoring divide on magnitudes one bit per cycle for 32 cycles, then go to DONE; for signed ops quotient sign = a[31]^b[31] and remainder sign = a[31].
REQ-020 SHALL compute all arithmetic modulo 2^32 per word: DIV 0x80000000/0xFFFFFFFF gives lo=0x80000000, hi=0.
REQ-021 SHALL treat b=0 with DIV/DIVU as a 1-cycle op: DIV state goes to DONE next cycle with lo=0xFFFFFFFF and hi=a (raw).
REQ-022 SHALL give this latency, with start seen in IDLE at cycle T: DONE and valid=1 at T+33; b=0 divide gives DONE at T+2.
REQ-023 SHALL hold hi/lo/valid stable in DONE until ack=1, then go to IDLE with valid=0 the next cycle; start is ignored in DONE.
REQ-024 SHALL, on flush=1 in any state, go to IDLE the next cycle with valid=0, hi/lo unchanged, and no result produced; flush overrides start and ack in the same cycle.
REQ-025 SHALL ignore ack outside DONE.

Reset
REQ-026 SHALL, on reset (asynchronous, any state including mid-iteration), set state=IDLE, counter=0, valid=0, hi=0 and lo=0; ok=1 whenever start=0.
REQ-027 SHALL leave no partial result visible after reset.

Configuration
REQ-028 SHALL recognise the macro MULDIV_FAST_MUL_EN.
REQ-029 SHALL, when MULDIV_FAST_MUL_EN is defined, compute MUL in a single cycle (signed/unsigned 33x33 multiply, registered), giving DONE at T+2; DIV is unchanged.
REQ-030 SHALL, when MULDIV_FAST_MUL_EN is undefined, use the iterative 32-cycle MUL of REQ-018.

Verification
REQ-031 SHALL verify: MULT a=0xFFFFFFFD, b=7 -> at T+33 valid=1, hi=0xFFFFFFFF, lo=0xFFFFFFEB (T+2 with MULDIV_FAST_MUL_EN).
REQ-032 SHALL verify: DIVU a=100, b=7 -> lo=14, hi=2; DIV a=0xFFFFFFF9, b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; both at T+33.
REQ-033 SHALL verify: DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0; DIV a=5, b=0 -> at T+2 lo=0xFFFFFFFF, hi=5.
REQ-034 SHALL verify: DIVU started, flush=1 at T+10 -> IDLE at T+11, valid never rises, and ok=1 with start=0.
REQ-035 SHALL verify: result in DONE with ack=0 for 5 cycles -> hi/lo/valid stable and ok=1; ack=1 -> valid=0 next cycle.
REQ-036 SHALL verify: reset pulse at T+20 of a MULTU -> immediately state IDLE, valid=0, hi=0, lo=0; a new op after reset completes correctly.
